// File: rtl/rv32i_ctrl_pkg.sv
// Shared encodings for the RV32I control/execute slice: opcodes, ALU codes,
// next-PC and write-back selects, branch funct3 codes. Optional macro: RV32M_EN.
package rv32i_ctrl_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_MULDIV  = 7'b0000001;

  localparam logic [2:0] BR_EQ  = 3'b000;
  localparam logic [2:0] BR_NE  = 3'b001;
  localparam logic [2:0] BR_LT  = 3'b100;
  localparam logic [2:0] BR_GE  = 3'b101;
  localparam logic [2:0] BR_LTU = 3'b110;
  localparam logic [2:0] BR_GEU = 3'b111;

  typedef enum logic [4:0] {
    ALU_ADD    = 5'd0,
    ALU_SUB    = 5'd1,
    ALU_SLL    = 5'd2,
    ALU_SLT    = 5'd3,
    ALU_SLTU   = 5'd4,
    ALU_XOR    = 5'd5,
    ALU_SRL    = 5'd6,
    ALU_SRA    = 5'd7,
    ALU_OR     = 5'd8,
    ALU_AND    = 5'd9,
    ALU_PASSB  = 5'd10
`ifdef RV32M_EN
    ,
    ALU_MUL    = 5'd16,
    ALU_MULH   = 5'd17,
    ALU_MULHSU = 5'd18,
    ALU_MULHU  = 5'd19,
    ALU_DIV    = 5'd20,
    ALU_DIVU   = 5'd21,
    ALU_REM    = 5'd22,
    ALU_REMU   = 5'd23
`endif
  } alu_op_e;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JAL    = 2'b10,
    PC_JALR   = 2'b11
  } orig_pc_e;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_PC4  = 2'b01,
    WB_MEM  = 2'b10,
    WB_ZERO = 2'b11
  } mem2reg_e;

  // alt selects SUB/SRA; the caller decides when funct7[5] is meaningful
  function automatic alu_op_e alu_op_from_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

`ifdef RV32M_EN
  function automatic alu_op_e m_op_from_f3(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_MUL;
      3'b001:  return ALU_MULH;
      3'b010:  return ALU_MULHSU;
      3'b011:  return ALU_MULHU;
      3'b100:  return ALU_DIV;
      3'b101:  return ALU_DIVU;
      3'b110:  return ALU_REM;
      default: return ALU_REMU;
    endcase
  endfunction
`endif

endpackage

// File: rtl/rv32i_ctrl_exec_alu.sv
// 32-bit combinational ALU; M-extension multiply/divide added when RV32M_EN is defined.
module rv32_alu_core
  import rv32i_ctrl_pkg::*;
(
  input  alu_op_e     op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] result_o
);

  logic [4:0] shamt;
  assign shamt = b_i[4:0];

`ifdef RV32M_EN
  logic        a_sx;
  logic        b_sx;
  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic [63:0] prod;
  logic        div_zero;
  logic        div_ovf;
  logic [31:0] quot_s;
  logic [31:0] rem_s;

  // One shared multiplier: operand extension picks signed/unsigned flavour
  assign a_sx  = ((op_i == ALU_MULH) || (op_i == ALU_MULHSU)) & a_i[31];
  assign b_sx  = (op_i == ALU_MULH) & b_i[31];
  assign a_ext = {{32{a_sx}}, a_i};
  assign b_ext = {{32{b_sx}}, b_i};
  assign prod  = a_ext * b_ext;

  assign div_zero = (b_i == '0);
  assign div_ovf  = (a_i == 32'h8000_0000) && (b_i == '1);
  assign quot_s   = (div_zero || div_ovf) ? '0 : $signed(a_i) / $signed(b_i);
  assign rem_s    = (div_zero || div_ovf) ? '0 : $signed(a_i) % $signed(b_i);
`endif

  always_comb begin
    result_o = '0;
    case (op_i)
      ALU_ADD:    result_o = a_i + b_i;
      ALU_SUB:    result_o = a_i - b_i;
      ALU_SLL:    result_o = a_i << shamt;
      ALU_SLT:    result_o = {31'b0, $signed(a_i) < $signed(b_i)};
      ALU_SLTU:   result_o = {31'b0, a_i < b_i};
      ALU_XOR:    result_o = a_i ^ b_i;
      ALU_SRL:    result_o = a_i >> shamt;
      ALU_SRA:    result_o = $signed(a_i) >>> shamt;
      ALU_OR:     result_o = a_i | b_i;
      ALU_AND:    result_o = a_i & b_i;
      ALU_PASSB:  result_o = b_i;
`ifdef RV32M_EN
      ALU_MUL:    result_o = prod[31:0];
      ALU_MULH:   result_o = prod[63:32];
      ALU_MULHSU: result_o = prod[63:32];
      ALU_MULHU:  result_o = prod[63:32];
      ALU_DIV:    result_o = div_zero ? '1 : (div_ovf ? 32'h8000_0000 : quot_s);
      ALU_DIVU:   result_o = div_zero ? '1 : a_i / b_i;
      ALU_REM:    result_o = div_zero ? a_i : (div_ovf ? '0 : rem_s);
      ALU_REMU:   result_o = div_zero ? a_i : a_i % b_i;
`endif
      default:    result_o = '0;
    endcase
  end

endmodule

// File: rtl/rv32i_ctrl_exec.sv
// Single-cycle RV32I control/execute: decode, ALU, branch compare, next-PC and PC register.
// Optional macro RV32M_EN enables the M-extension on OP with funct7=0000001.
module rv32i_ctrl_exec
  import rv32i_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic [31:0] iInitialPC,
  input  logic [31:0] iInstr,
  input  logic [31:0] iRead1,
  input  logic [31:0] iRead2,
  input  logic [31:0] iImm,
  input  logic [31:0] iMemLoad,
  output logic [31:0] oPC,
  output logic [31:0] oALUResult,
  output logic        oZero,
  output logic        oRegWrite,
  output logic [31:0] oRegWriteData,
  output logic        oMemRead,
  output logic        oMemWrite,
  output logic        oBranch
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;

  logic        orig_a;
  logic        orig_b;
  logic        reg_write;
  logic        mem_read;
  logic        mem_write;
  mem2reg_e    mem2reg;
  orig_pc_e    orig_pc;
  alu_op_e     alu_op;

  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_res;
  logic [31:0] pc_plus4;
  logic [31:0] pc_imm;
  logic        br_cond;

  // Register fields are consumed by the register file, not here
  logic unused_ok;
  assign unused_ok = ^{iInstr[24:15], iInstr[11:7], RESET_PC_DEFAULT};

  assign opcode = iInstr[6:0];
  assign funct3 = iInstr[14:12];
  assign funct7 = iInstr[31:25];

  always_comb begin
    orig_a    = 1'b0;
    orig_b    = 1'b0;
    reg_write = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem2reg   = WB_ALU;
    orig_pc   = PC_PLUS4;
    alu_op    = ALU_ADD;
    case (opcode)
      OPC_OP: begin
        if (funct7 == F7_MULDIV) begin
`ifdef RV32M_EN
          reg_write = 1'b1;
          alu_op    = m_op_from_f3(funct3);
`endif
        end else begin
          reg_write = 1'b1;
          alu_op    = alu_op_from_f3(funct3, funct7[5]);
        end
      end
      OPC_OPIMM: begin
        orig_b    = 1'b1;
        reg_write = 1'b1;
        // Bit 30 of an I-immediate is only an opcode bit for SRAI
        alu_op    = alu_op_from_f3(funct3, funct7[5] & (funct3 == 3'b101));
      end
      OPC_LOAD: begin
        orig_b    = 1'b1;
        mem_read  = 1'b1;
        reg_write = 1'b1;
        mem2reg   = WB_MEM;
      end
      OPC_STORE: begin
        orig_b    = 1'b1;
        mem_write = 1'b1;
      end
      OPC_BRANCH: begin
        orig_pc = PC_BRANCH;
        alu_op  = ALU_SUB;
      end
      OPC_JAL: begin
        reg_write = 1'b1;
        mem2reg   = WB_PC4;
        orig_pc   = PC_JAL;
      end
      OPC_JALR: begin
        reg_write = 1'b1;
        mem2reg   = WB_PC4;
        orig_pc   = PC_JALR;
      end
      OPC_LUI: begin
        orig_b    = 1'b1;
        reg_write = 1'b1;
        alu_op    = ALU_PASSB;
      end
      OPC_AUIPC: begin
        orig_a    = 1'b1;
        orig_b    = 1'b1;
        reg_write = 1'b1;
      end
      default: ;
    endcase
  end

  assign alu_a = orig_a ? pc_q : iRead1;
  assign alu_b = orig_b ? iImm : iRead2;

  rv32_alu_core u_alu (
    .op_i     (alu_op),
    .a_i      (alu_a),
    .b_i      (alu_b),
    .result_o (alu_res)
  );

  always_comb begin
    br_cond = 1'b0;
    case (funct3)
      BR_EQ:   br_cond = (iRead1 == iRead2);
      BR_NE:   br_cond = (iRead1 != iRead2);
      BR_LT:   br_cond = ($signed(iRead1) <  $signed(iRead2));
      BR_GE:   br_cond = ($signed(iRead1) >= $signed(iRead2));
      BR_LTU:  br_cond = (iRead1 <  iRead2);
      BR_GEU:  br_cond = (iRead1 >= iRead2);
      default: br_cond = 1'b0;
    endcase
  end

  assign pc_plus4 = pc_q + 32'd4;
  assign pc_imm   = pc_q + iImm;

  always_comb begin
    pc_d = pc_plus4;
    case (orig_pc)
      PC_PLUS4:  pc_d = pc_plus4;
      PC_BRANCH: pc_d = oBranch ? pc_imm : pc_plus4;
      PC_JAL:    pc_d = pc_imm;
      PC_JALR:   pc_d = (iRead1 + iImm) & ~32'h1;
      default:   pc_d = pc_plus4;
    endcase
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) pc_q <= iInitialPC;
    else      pc_q <= pc_d;
  end

  always_comb begin
    oRegWriteData = alu_res;
    case (mem2reg)
      WB_ALU:  oRegWriteData = alu_res;
      WB_PC4:  oRegWriteData = pc_plus4;
      WB_MEM:  oRegWriteData = iMemLoad;
      WB_ZERO: oRegWriteData = '0;
      default: oRegWriteData = '0;
    endcase
  end

  assign oPC        = pc_q;
  assign oALUResult = alu_res;
  assign oZero      = (alu_res == '0);
  assign oRegWrite  = reg_write;
  assign oMemRead   = mem_read;
  assign oMemWrite  = mem_write;
  assign oBranch    = (opcode == OPC_BRANCH) && br_cond;

endmodule

// File: tb/tb_rv32i_ctrl_exec.sv
// Directed bench for rv32i_ctrl_exec; M-extension vectors run when RV32M_EN is defined.
module tb_rv32i_ctrl_exec;

  logic        iCLK;
  logic        iRST;
  logic [31:0] iInitialPC;
  logic [31:0] iInstr;
  logic [31:0] iRead1;
  logic [31:0] iRead2;
  logic [31:0] iImm;
  logic [31:0] iMemLoad;
  logic [31:0] oPC;
  logic [31:0] oALUResult;
  logic        oZero;
  logic        oRegWrite;
  logic [31:0] oRegWriteData;
  logic        oMemRead;
  logic        oMemWrite;
  logic        oBranch;

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  rv32i_ctrl_exec #(.RESET_PC_DEFAULT(32'h0040_0000)) dut (
    .iCLK          (iCLK),
    .iRST          (iRST),
    .iInitialPC    (iInitialPC),
    .iInstr        (iInstr),
    .iRead1        (iRead1),
    .iRead2        (iRead2),
    .iImm          (iImm),
    .iMemLoad      (iMemLoad),
    .oPC           (oPC),
    .oALUResult    (oALUResult),
    .oZero         (oZero),
    .oRegWrite     (oRegWrite),
    .oRegWriteData (oRegWriteData),
    .oMemRead      (oMemRead),
    .oMemWrite     (oMemWrite),
    .oBranch       (oBranch)
  );

  initial begin
    iCLK = 1'b0;
    forever #5 iCLK = ~iCLK;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic apply(input logic [31:0] instr, input logic [31:0] r1,
                       input logic [31:0] r2, input logic [31:0] imm);
    iInstr = instr;
    iRead1 = r1;
    iRead2 = r2;
    iImm   = imm;
    #1;
  endtask

  task automatic do_reset(input logic [31:0] pc);
    @(negedge iCLK);
    iInitialPC = pc;
    iRST = 1'b1;
    #1;
    iRST = 1'b0;
  endtask

  initial begin
    iRST       = 1'b0;
    iInitialPC = 32'h0040_0000;
    iInstr     = 32'h0050_0093;
    iRead1     = '0;
    iRead2     = '0;
    iImm       = 32'd5;
    iMemLoad   = 32'hDEAD_BEEF;
    #1 iRST = 1'b1;
    #1;
    chk("rst_pc", oPC, 32'h0040_0000);
    chk("rst_decode_alu", oALUResult, 32'd5);

    // Release reset: ADDI x1,x0,5
    @(negedge iCLK);
    iRST = 1'b0;
    #1;
    chk("addi_alu", oALUResult, 32'd5);
    chk("addi_regwrite", {31'b0, oRegWrite}, 32'd1);
    chk("addi_wbdata", oRegWriteData, 32'd5);
    chk("addi_pc_hold", oPC, 32'h0040_0000);
    @(posedge iCLK); #1;
    chk("addi_next_pc", oPC, 32'h0040_0004);

    // R-type
    @(negedge iCLK); apply(32'h4020_81B3, 32'd3, 32'd5, 32'h0);
    chk("sub_res", oALUResult, 32'hFFFF_FFFE);
    chk("sub_zero_lo", {31'b0, oZero}, 32'd0);
    @(negedge iCLK); apply(32'h4020_81B3, 32'd5, 32'd5, 32'h0);
    chk("sub_zero_hi", {31'b0, oZero}, 32'd1);
    @(negedge iCLK); apply(32'h4020_D1B3, 32'h8000_0000, 32'd4, 32'h0);
    chk("sra_res", oALUResult, 32'hF800_0000);
    @(negedge iCLK); apply(32'h0020_B1B3, 32'd1, 32'hFFFF_FFFF, 32'h0);
    chk("sltu_res", oALUResult, 32'd1);

    // OP-IMM: ADDI with imm bit 30 set must not subtract; SRLI/SRAI
    @(negedge iCLK); apply(32'hFFF0_8193, 32'd10, 32'd77, 32'hFFFF_FFFF);
    chk("addi_neg", oALUResult, 32'd9);
    @(negedge iCLK); apply(32'h0040_D193, 32'h8000_0000, 32'd0, 32'd4);
    chk("srli_res", oALUResult, 32'h0800_0000);
    @(negedge iCLK); apply(32'h4040_D193, 32'h8000_0000, 32'd0, 32'h0000_0404);
    chk("srai_res", oALUResult, 32'hF800_0000);

    // Branches
    do_reset(32'h0000_0100);
    apply(32'h0020_C063, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFF8);
    chk("blt_taken", {31'b0, oBranch}, 32'd1);
    chk("blt_regwrite", {31'b0, oRegWrite}, 32'd0);
    @(posedge iCLK); #1;
    chk("blt_next_pc", oPC, 32'h0000_00F8);

    do_reset(32'h0000_0100);
    apply(32'h0020_E063, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFF8);
    chk("bltu_not_taken", {31'b0, oBranch}, 32'd0);
    @(posedge iCLK); #1;
    chk("bltu_next_pc", oPC, 32'h0000_0104);

    do_reset(32'h0000_0100);
    apply(32'h0020_A063, 32'd9, 32'd9, 32'h0000_0010);
    chk("br_f3_010", {31'b0, oBranch}, 32'd0);
    @(posedge iCLK); #1;
    chk("br_f3_010_pc", oPC, 32'h0000_0104);

    // Jumps
    do_reset(32'h0000_0200);
    apply(32'h0000_00EF, 32'h0, 32'h0, 32'h0000_0040);
    chk("jal_wbdata", oRegWriteData, 32'h0000_0204);
    chk("jal_regwrite", {31'b0, oRegWrite}, 32'd1);
    @(posedge iCLK); #1;
    chk("jal_next_pc", oPC, 32'h0000_0240);
    @(negedge iCLK); apply(32'h0000_00E7, 32'h0000_0301, 32'h0, 32'd2);
    chk("jalr_wbdata", oRegWriteData, 32'h0000_0244);
    @(posedge iCLK); #1;
    chk("jalr_next_pc", oPC, 32'h0000_0302);

    // Memory
    @(negedge iCLK); apply(32'h0080_A103, 32'h0000_1000, 32'h0, 32'd8);
    chk("lw_addr", oALUResult, 32'h0000_1008);
    chk("lw_memread", {31'b0, oMemRead}, 32'd1);
    chk("lw_wbdata", oRegWriteData, 32'hDEAD_BEEF);
    chk("lw_memwrite", {31'b0, oMemWrite}, 32'd0);
    @(negedge iCLK); apply(32'h0020_A423, 32'h0000_2000, 32'h55, 32'd8);
    chk("sw_memwrite", {31'b0, oMemWrite}, 32'd1);
    chk("sw_regwrite", {31'b0, oRegWrite}, 32'd0);
    chk("sw_addr", oALUResult, 32'h0000_2008);

    // Upper immediates
    @(negedge iCLK); apply(32'h1234_50B7, 32'hAAAA_AAAA, 32'h0, 32'h1234_5000);
    chk("lui_res", oALUResult, 32'h1234_5000);
    do_reset(32'h0040_0010);
    apply(32'h0000_1097, 32'hAAAA_AAAA, 32'h0, 32'h1234_5000);
    chk("auipc_res", oRegWriteData, 32'h1274_5010);

    // FENCE behaves as a NOP
    do_reset(32'h0000_0500);
    apply(32'h0000_000F, 32'd3, 32'd4, 32'h0);
    chk("nop_regwrite", {31'b0, oRegWrite}, 32'd0);
    chk("nop_mem", {30'b0, oMemRead, oMemWrite}, 32'd0);
    chk("nop_alu_add", oALUResult, 32'd7);
    @(posedge iCLK); #1;
    chk("nop_next_pc", oPC, 32'h0000_0504);

`ifdef RV32M_EN
    @(negedge iCLK); apply(32'h0220_C1B3, 32'd7, 32'd0, 32'h0);
    chk("div_by_zero", oALUResult, 32'hFFFF_FFFF);
    chk("div_regwrite", {31'b0, oRegWrite}, 32'd1);
    @(negedge iCLK); apply(32'h0220_E1B3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
    chk("rem_ovf", oALUResult, 32'h0000_0000);
    @(negedge iCLK); apply(32'h0220_C1B3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
    chk("div_ovf", oALUResult, 32'h8000_0000);
    @(negedge iCLK); apply(32'h0220_B1B3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0);
    chk("mulhu_res", oALUResult, 32'hFFFF_FFFE);
`else
    @(negedge iCLK); apply(32'h0220_C1B3, 32'd7, 32'd0, 32'h0);
    chk("m_as_nop_regwrite", {31'b0, oRegWrite}, 32'd0);
    chk("m_as_nop_alu", oALUResult, 32'd7);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/rv32i_ctrl_exec.md
Name: rv32i_ctrl_exec

Overview:
- Single-cycle RV32I control/execute core: instruction decode (main control), 32-bit ALU, branch comparator, next-PC logic and PC register.
- Sits between instruction fetch, register file, immediate generator and data-memory load/store units of the uniciclo datapath.
- Produces PC, ALU result/data address, memory strobes and register write-back data/enable.

Parameters:
- RESET_PC_DEFAULT, 32'h0040_0000, documentation only; actual reset PC comes from iInitialPC.

Ports:
- iCLK  in  1  clock, rising edge.
- iRST  in  1  reset, asynchronous, active-high.
- iInitialPC  in  32  PC loaded on reset.
- iInstr  in  32  instruction at oPC.
- iRead1  in  32  rs1 value.
- iRead2  in  32  rs2 value.
- iImm  in  32  sign-extended immediate from external ImmGen.
- iMemLoad  in  32  aligned/extended load data.
- oPC  out  32  current PC.
- oALUResult  out  32  ALU result; also data address.
- oZero  out  1  ALU result == 0.
- oRegWrite  out  1  register-file write enable.
- oRegWriteData  out  32  write-back data.
- oMemRead  out  1  data read enable.
- oMemWrite  out  1  data write enable.
- oBranch  out  1  branch condition true.

Behaviour:
- Only the PC is sequential. Everything else is combinational from iInstr/iRead*/iImm/iMemLoad/PC.
- PC register:
  - iRST high (async): PC <= iInitialPC.
  - Otherwise PC <= nextPC on each rising iCLK.
- Decode is by opcode iInstr[6:0], giving OrigA (0 = rs1, 1 = PC), OrigB (0 = rs2, 1 = imm), Mem2Reg, RegWrite, MemRead, MemWrite, OrigPC:
  - OP 0110011: A=rs1, B=rs2, Mem2Reg=00, RegWrite=1, OrigPC=00; ALU op from funct3 + funct7[5].
  - OP-IMM 0010011: B=imm, otherwise as OP. funct7[5] is honoured only for SRAI; ADDI never subtracts.
  - LOAD 0000011: B=imm, ALU ADD, MemRead=1, RegWrite=1, Mem2Reg=10.
  - STORE 0100011: B=imm, ALU ADD, MemWrite=1.
  - BRANCH 1100011: OrigPC=01, ALU SUB on rs1/rs2.
  - JAL 1101111: RegWrite=1, Mem2Reg=01, OrigPC=10.
  - JALR 1100111: RegWrite=1, Mem2Reg=01, OrigPC=11.
  - LUI 0110111: B=imm, ALU PASSB, RegWrite=1.
  - AUIPC 0010111: A=PC, B=imm, ALU ADD, RegWrite=1.
  - Any other opcode (FENCE, SYSTEM, illegal): NOP. All enables 0, OrigPC=00, ALU ADD.
- ALU codes (5-bit): ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASSB.
  - Shift amount is B[4:0].
  - SLT/SLTU return 32'h1 or 32'h0.
  - Undefined code returns 0.
  - Arithmetic wraps modulo 2^32.
- Branch compare by funct3:
  - 000 EQ, 001 NE, 100 signed LT, 101 signed GE, 110 unsigned LT, 111 unsigned GE.
  - 010 and 011 are never taken.
- nextPC:
  - 00: PC+4.
  - 01: oBranch ? PC+imm : PC+4.
  - 10: PC+imm.
  - 11: (rs1+imm) & ~32'h1.
- Write-back mux: Mem2Reg 00 -> ALU result, 01 -> PC+4, 10 -> iMemLoad, 11 -> 0.
- oRegWrite is not masked for rd=x0; the register file ignores x0 writes.
- During reset: oPC = iInitialPC; outputs follow decode of iInstr.

Optional Feature:
- Macro RV32M_EN.
- Defined: OP with funct7=0000001 decodes to MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU (combinational).
  - Divide by zero: DIV/DIVU = 32'hFFFF_FFFF; REM/REMU = dividend.
  - Signed overflow (0x8000_0000 / -1): DIV = 0x8000_0000, REM = 0.
- Undefined: funct7=0000001 on OP is treated as a NOP; no M-extension ALU codes exist.

Decomposition:
- Package rv32i_ctrl_pkg holds:
  - opcode constants;
  - 5-bit ALU op codes;
  - OrigPC and Mem2Reg encodings;
  - funct3 branch codes.
- One natural sub-module: rv32_alu_core (ALU datapath incl. optional M ops).
- Decode, branch compare and PC logic stay in the top.

Test Plan:
- Reset: iRST=1 with iInitialPC=0x0040_0000 -> oPC=0x0040_0000 immediately. Release, instr ADDI x1,x0,5 (0x00500093), iImm=5 -> oALUResult=5, oRegWrite=1; next edge oPC=0x0040_0004.
- R-type: SUB with rs1=3, rs2=5 -> 0xFFFF_FFFE. SRA of 0x8000_0000 by 4 -> 0xF800_0000. SLTU of 1 vs 0xFFFF_FFFF -> 1.
- Branch: BLT rs1=-1, rs2=1, imm=-8 at PC=0x100 -> oBranch=1, next PC=0xF8. BLTU with the same operands -> next PC=0x104.
- Jumps: JAL at PC=0x200, imm=0x40 -> oRegWriteData=0x204, next PC=0x240. JALR rs1=0x301, imm=2 -> next PC=0x302.
- Memory: LW rs1=0x1000, imm=8 -> oALUResult=0x1008, oMemRead=1, oRegWriteData=iMemLoad. SW -> oMemWrite=1, oRegWrite=0.
- With RV32M_EN: DIV 7/0 -> 0xFFFF_FFFF; REM 0x8000_0000 % -1 -> 0; MULHU 0xFFFF_FFFF*0xFFFF_FFFF -> 0xFFFF_FFFE.
